// File: rtl/rng_pkg.sv
// Shared state encoding and default parameter values for the TRNG sequencer.
package rng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    VALID,
    FAIL
  } rng_state_t;

  localparam int DEF_WORD_W        = 32;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_SAMPLE_DIV    = 4;
  localparam int DEF_REP_LIMIT     = 16;

endpackage

// File: rtl/rng_health_rct.sv
// Repetition-count health test: trips on the sample that makes REP_LIMIT
// consecutive identical raw samples.
module rng_health_rct
  import rng_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sample_vld,
  input  logic sample,
  output logic trip
);

  localparam int CW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(REP_LIMIT - 1);
  localparam logic [CW-1:0] TOP  = CW'(REP_LIMIT);

  logic [CW-1:0] cnt;
  logic          prev;
  logic          match;

  // A zero count means no previous sample, so prev is ignored until loaded.
  assign match = sample_vld && (cnt != '0) && (sample == prev);
  assign trip  = match && (cnt >= LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (sample_vld) begin
      if (!match)
        cnt <= CW'(1);
      else if (cnt != TOP)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sample_vld)
      prev <= sample;
  end

endmodule

// File: rtl/rng_ctrl.sv
// TRNG sequencer: warm-up, decimated sampling, word packing, health lockout.
// Optional macro RNG_VN_DEBIAS_EN adds Von Neumann debiasing of raw samples.
module rng_ctrl
  import rng_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rng_bit,
  output logic              rng_enable,
  output logic [WORD_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              health_fail,
  input  logic              fail_clr
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_W + 1);

  rng_state_t     state, state_nx;
  logic [WCW-1:0] warm_cnt;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic           strobe, acc, acc_bit, trip, word_done;
  logic           rng_enable_nx, busy_nx, data_valid_nx, health_fail_nx;

  assign strobe = (state == COLLECT) && en && (div_cnt == DCW'(SAMPLE_DIV - 1));

`ifdef RNG_VN_DEBIAS_EN
  logic half, first;

  // Pair 01 emits 0 and 10 emits 1, i.e. the first bit of an unequal pair.
  assign acc     = strobe && half && (first != rng_bit);
  assign acc_bit = first;

  always_ff @(posedge clk) begin
    if (rst || state != COLLECT)
      half <= 1'b0;
    else if (strobe)
      half <= !half;
  end

  always_ff @(posedge clk) begin
    if (strobe && !half)
      first <= rng_bit;
  end
`else
  assign acc     = strobe;
  assign acc_bit = rng_bit;
`endif

  assign word_done = acc && (bit_cnt == BCW'(WORD_W - 1));

  rng_health_rct #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rct (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == WARMUP),
    .sample_vld(strobe),
    .sample    (rng_bit),
    .trip      (trip)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = WARMUP;
      WARMUP: begin
        if (!en)
          state_nx = IDLE;
        else if (warm_cnt == WCW'(WARMUP_CYCLES - 1))
          state_nx = COLLECT;
      end
      COLLECT: begin
        // Health trip outranks word completion on the same strobe.
        if (trip)
          state_nx = FAIL;
        else if (!en)
          state_nx = IDLE;
        else if (word_done)
          state_nx = VALID;
      end
      VALID:   if (data_ready) state_nx = en ? COLLECT : IDLE;
      FAIL:    if (fail_clr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    rng_enable_nx  = (state_nx == WARMUP) || (state_nx == COLLECT) || (state_nx == VALID);
    busy_nx        = (state_nx == WARMUP) || (state_nx == COLLECT);
    data_valid_nx  = (state_nx == VALID);
    health_fail_nx = (state_nx == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rng_enable  <= 1'b0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      state       <= state_nx;
      rng_enable  <= rng_enable_nx;
      busy        <= busy_nx;
      data_valid  <= data_valid_nx;
      health_fail <= health_fail_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      warm_cnt <= (state == WARMUP) ? warm_cnt + 1'b1 : '0;
      div_cnt  <= (state == COLLECT && en && !strobe) ? div_cnt + 1'b1 : '0;
      if (state != COLLECT)
        bit_cnt <= '0;
      else if (acc)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      data <= '0;
    else if (acc)
      data <= {data[WORD_W-2:0], acc_bit};
  end

endmodule

// File: tb/tb_rng_ctrl.sv
// Directed bench for rng_ctrl; covers the debiased build when RNG_VN_DEBIAS_EN is set.
module tb_rng_ctrl;

`ifdef RNG_VN_DEBIAS_EN
  localparam int W  = 4;
  localparam int RL = 8;
`else
  localparam int W  = 8;
  localparam int RL = 4;
`endif

  logic         clk = 1'b0;
  logic         rst, en, rng_bit, data_ready, fail_clr;
  logic         rng_enable, data_valid, busy, health_fail;
  logic [W-1:0] data;
  int           vectors = 0;
  int           miscompares = 0;

  rng_ctrl #(
    .WORD_W       (W),
    .WARMUP_CYCLES(4),
    .SAMPLE_DIV   (2),
    .REP_LIMIT    (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rng_bit    (rng_bit),
    .rng_enable (rng_enable),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .health_fail(health_fail),
    .fail_clr   (fail_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; rng_bit = 1'b0; data_ready = 1'b0; fail_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    vectors++;
    if ({rng_enable, data_valid, busy, health_fail} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {rng_enable, data_valid, busy, health_fail});
    end
    vectors++;
    if (data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", data);
    end
  endtask

  task automatic test_reset_in_valid;
    rst = 1'b1;
    tick;
    rst = 1'b0; en = 1'b0;
    vectors++;
    if ({rng_enable, data_valid, busy, health_fail} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_valid_flags: got %b want 0000", {rng_enable, data_valid, busy, health_fail});
    end
    vectors++;
    if (data !== '0) begin
      miscompares++;
      $display("FAIL rst_valid_data: got %h want 0", data);
    end
  endtask

`ifdef RNG_VN_DEBIAS_EN
  task automatic test_debias;
    logic [13:0] raw;
    int          dexp [7];
    raw  = 14'b01_11_10_00_10_01_10;
    dexp = '{0, 0, 1, 1, 3, 6, 6};
    en = 1'b1; data_ready = 1'b0;
    repeat (5) tick;
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 2; k++) begin
        rng_bit = raw[13 - (2 * p + k)];
        tick; tick;
      end
      vectors++;
      if ({data_valid, data} !== {logic'(p >= 5), 4'(dexp[p])}) begin
        miscompares++;
        $display("FAIL debias_pair%0d: got valid=%b data=%b want valid=%b data=%b",
                 p + 1, data_valid, data, logic'(p >= 5), 4'(dexp[p]));
      end
    end
    vectors++;
    if ({rng_enable, busy, health_fail} !== 3'b100) begin
      miscompares++;
      $display("FAIL debias_flags: got %b want 100", {rng_enable, busy, health_fail});
    end
  endtask
`else
  task automatic test_first_word;
    logic [7:0] pat;
    pat = 8'hAA;
    en = 1'b1; data_ready = 1'b1;
    tick;
    vectors++;
    if ({rng_enable, busy, data_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL warmup_flags: got %b want 110", {rng_enable, busy, data_valid});
    end
    repeat (4) tick;
    for (int i = 7; i >= 0; i--) begin
      rng_bit = pat[i];
      tick;
      if (i == 0) begin
        vectors++;
        if (data_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL first_early: got valid=%b want 0 at cycle 20", data_valid);
        end
      end
      tick;
    end
    vectors++;
    if ({data_valid, busy, rng_enable, data} !== {3'b101, 8'hAA}) begin
      miscompares++;
      $display("FAIL first_word: got vld/busy/en=%b data=%h want 101 aa",
               {data_valid, busy, rng_enable}, data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat;
    pat = 8'hC9;
    tick;
    vectors++;
    if ({data_valid, busy, rng_enable} !== 3'b011) begin
      miscompares++;
      $display("FAIL b2b_collect: got %b want 011", {data_valid, busy, rng_enable});
    end
    for (int i = 7; i >= 0; i--) begin
      rng_bit = pat[i];
      tick; tick;
    end
    data_ready = 1'b0;
    vectors++;
    if ({data_valid, data} !== {1'b1, 8'hC9}) begin
      miscompares++;
      $display("FAIL b2b_word: got valid=%b data=%h want 1 c9", data_valid, data);
    end
  endtask

  task automatic test_hold_ready;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) en = 1'b0;
      tick;
      vectors++;
      if ({data_valid, rng_enable, data} !== {2'b11, 8'hC9}) begin
        miscompares++;
        $display("FAIL hold_%0d: got vld/en=%b data=%h want 11 c9", i, {data_valid, rng_enable}, data);
      end
    end
    data_ready = 1'b1;
    tick;
    data_ready = 1'b0;
    vectors++;
    if ({data_valid, rng_enable, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL hold_release: got %b want 000", {data_valid, rng_enable, busy});
    end
  endtask

  task automatic test_abort;
    logic [7:0] pat;
    en = 1'b1;
    repeat (5) tick;
    pat = 8'b110_00000;
    for (int i = 7; i >= 5; i--) begin
      rng_bit = pat[i];
      tick; tick;
    end
    en = 1'b0;
    tick;
    vectors++;
    if ({busy, rng_enable, data_valid, data} !== {3'b000, 8'h4E}) begin
      miscompares++;
      $display("FAIL abort_idle: got busy/en/vld=%b data=%h want 000 4e",
               {busy, rng_enable, data_valid}, data);
    end
    en = 1'b1;
    tick;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_rewarm: got busy=%b want 1", busy);
    end
    repeat (4) tick;
    pat = 8'h35;
    for (int i = 7; i >= 0; i--) begin
      rng_bit = pat[i];
      tick;
      if (i == 0) begin
        vectors++;
        if (data_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_early: got valid=%b want 0", data_valid);
        end
      end
      tick;
    end
    vectors++;
    if ({data_valid, data} !== {1'b1, 8'h35}) begin
      miscompares++;
      $display("FAIL abort_word: got valid=%b data=%h want 1 35", data_valid, data);
    end
  endtask

  task automatic test_health;
    rng_bit = 1'b1; en = 1'b1;
    repeat (5) tick;
    for (int s = 1; s <= 4; s++) begin
      tick;
      if (s == 4) begin
        vectors++;
        if ({health_fail, busy} !== 2'b01) begin
          miscompares++;
          $display("FAIL health_early: got fail/busy=%b want 01", {health_fail, busy});
        end
      end
      tick;
    end
    vectors++;
    if ({health_fail, rng_enable, data_valid, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL health_trip: got %b want 1000", {health_fail, rng_enable, data_valid, busy});
    end
    repeat (3) tick;
    vectors++;
    if ({health_fail, rng_enable} !== 2'b10) begin
      miscompares++;
      $display("FAIL health_sticky: got %b want 10", {health_fail, rng_enable});
    end
    en = 1'b0; fail_clr = 1'b1;
    tick;
    fail_clr = 1'b0;
    vectors++;
    if ({health_fail, rng_enable, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL health_clear: got %b want 000", {health_fail, rng_enable, busy});
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef RNG_VN_DEBIAS_EN
    test_debias;
    test_reset_in_valid;
`else
    test_first_word;
    test_back_to_back;
    test_hold_ready;
    test_abort;
    test_reset_in_valid;
    test_health;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
